// File: rtl/lsu_mem_master_if.sv
// rtl/lsu_mem_master_if.sv - CPU-side and memory-side bus bundle for lsu_mem_master
//
// Purpose: groups the CPU request/response signals and the memory beat signals
// of the load/store unit into one bundle.
// Modports:
//   master : the LSU view (drives cpu_ready/done/err/rdata and all mem_* requests)
//   slave  : the environment view (CPU requester plus memory responder)
// Signals:
//   cpu_valid/cpu_ready       request handshake
//   cpu_we, cpu_size[1:0], cpu_unsigned, cpu_addr[31:0], cpu_wdata[31:0]
//   cpu_done, cpu_err, cpu_rdata[31:0]
//   mem_req, mem_we, mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]
//   mem_ack, mem_rdata[31:0]
interface lsu_mem_master_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_valid, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_err, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_err, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store unit memory master with lane alignment, optional split and beat timeout
//
// Purpose: accepts one CPU load/store at a time, issues word-aligned memory
// beats with byte strobes, assembles and extends load data, and reports
// completion with a one-cycle cpu_done pulse.
// Configuration macro: LSU_MISALIGN_SPLIT_EN
//   defined   : word-crossing accesses run as two beats (second at word addr + 4)
//   undefined : word-crossing accesses are rejected with cpu_err, no memory traffic
// Parameters:
//   TIMEOUT_CYCLES : max wait cycles per beat (0 disables the timeout)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lsu_mem_master_if.master (CPU request/response + memory beat signals)
module lsu_mem_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_mem_master_if.master      bus
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value at which one more un-acked cycle exhausts the budget.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t         r_state;
  state_t         w_next;

  logic           r_we;
  logic [1:0]     r_size;
  logic           r_unsigned;
  logic [1:0]     r_off;
  logic [31:0]    r_mem_addr;
  logic [3:0]     r_mem_wstrb;
  logic [31:0]    r_mem_wdata;
  logic           r_err;
  logic [31:0]    r_rdata;
  logic [CW-1:0]  r_wait_cnt;

  logic [1:0]     w_off;
  logic [3:0]     w_mask;
  logic [7:0]     w_strb8;
  logic [31:0]    w_b0_data;
  logic           w_cross;
  logic           w_bad_size;
  logic           w_reject;
  logic           w_accept;
  logic           w_mem_req;
  logic           w_ack;
  logic           w_last_ack;
  logic           w_timeout;
  logic           w_beat_restart;
  logic [31:0]    w_rd_word;
  logic [31:0]    w_load_val;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic           r_cross;
  logic [31:0]    r_b1_addr;
  logic [3:0]     r_b1_strb;
  logic [31:0]    r_b1_data;
  logic [31:0]    r_rd_lo;
  logic [31:0]    w_b1_data;
  logic [63:0]    w_rd64;
`endif

  // ---------------- request decode ----------------
  always_comb begin
    w_off = bus.cpu_addr[1:0];
    case (bus.cpu_size)
      2'd0:    w_mask = 4'h1;
      2'd1:    w_mask = 4'h3;
      default: w_mask = 4'hF;
    endcase
    // Upper nibble holds the lanes that spill into the next word.
    w_strb8    = {4'b0000, w_mask} << w_off;
    w_b0_data  = bus.cpu_wdata << {w_off, 3'b000};
    w_cross    = |w_strb8[7:4];
    w_bad_size = (bus.cpu_size == 2'd3);
    w_accept   = bus.cpu_valid && (r_state == S_IDLE);
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_reject  = w_bad_size;
  // Shift by 32 when off = 0 yields 0; that value is never used (no crossing).
  assign w_b1_data = bus.cpu_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
`else
  assign w_reject  = w_bad_size || w_cross;
`endif

  // ---------------- beat status ----------------
  assign w_mem_req = (r_state == S_BEAT0) || (r_state == S_BEAT1);
  // An ack outside a beat is meaningless and is dropped here.
  assign w_ack     = bus.mem_ack && w_mem_req;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_mem_req && !bus.mem_ack &&
                     (r_wait_cnt == TO_LAST);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_beat_restart = (r_state == S_BEAT0) && w_ack && r_cross;
  assign w_last_ack     = w_ack && ((r_state == S_BEAT1) || !r_cross);
  assign w_rd64         = (r_state == S_BEAT1) ? {bus.mem_rdata, r_rd_lo}
                                               : {32'h0, bus.mem_rdata};
  assign w_rd_word      = 32'(w_rd64 >> {r_off, 3'b000});
`else
  assign w_beat_restart = 1'b0;
  assign w_last_ack     = w_ack;
  assign w_rd_word      = bus.mem_rdata >> {r_off, 3'b000};
`endif

  always_comb begin
    case (r_size)
      2'd0:    w_load_val = r_unsigned ? {24'h0, w_rd_word[7:0]}
                                       : {{24{w_rd_word[7]}}, w_rd_word[7:0]};
      2'd1:    w_load_val = r_unsigned ? {16'h0, w_rd_word[15:0]}
                                       : {{16{w_rd_word[15]}}, w_rd_word[15:0]};
      default: w_load_val = w_rd_word;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_reject ? S_RESP : S_BEAT0;
      end
      S_BEAT0: begin
        if (w_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          w_next = r_cross ? S_BEAT1 : S_RESP;
`else
          w_next = S_RESP;
`endif
        end else if (w_timeout) begin
          w_next = S_RESP;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_BEAT1: begin
        if (w_ack || w_timeout) w_next = S_RESP;
      end
`endif
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.cpu_ready = (r_state == S_IDLE);
    bus.cpu_done  = (r_state == S_RESP);
    bus.cpu_err   = r_err;
    bus.cpu_rdata = r_rdata;
    bus.mem_req   = w_mem_req;
    bus.mem_we    = w_mem_req && r_we;
    bus.mem_addr  = r_mem_addr;
    bus.mem_wstrb = r_mem_wstrb;
    bus.mem_wdata = r_mem_wdata;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_off       <= 2'd0;
      r_mem_addr  <= 32'h0;
      r_mem_wstrb <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_wait_cnt  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_cross     <= 1'b0;
      r_b1_addr   <= 32'h0;
      r_b1_strb   <= 4'h0;
      r_b1_data   <= 32'h0;
      r_rd_lo     <= 32'h0;
`endif
    end else begin
      if (w_accept) begin
        r_we        <= bus.cpu_we;
        r_size      <= bus.cpu_size;
        r_unsigned  <= bus.cpu_unsigned;
        r_off       <= w_off;
        r_mem_addr  <= {bus.cpu_addr[31:2], 2'b00};
        r_mem_wstrb <= w_strb8[3:0];
        r_mem_wdata <= w_b0_data;
        r_err       <= w_reject;
`ifdef LSU_MISALIGN_SPLIT_EN
        r_cross     <= w_cross;
        // 32-bit add wraps 0xFFFFFFFC to 0x00000000.
        r_b1_addr   <= {bus.cpu_addr[31:2], 2'b00} + 32'd4;
        r_b1_strb   <= w_strb8[7:4];
        r_b1_data   <= w_b1_data;
`endif
      end

`ifdef LSU_MISALIGN_SPLIT_EN
      if (w_beat_restart) begin
        r_rd_lo     <= bus.mem_rdata;
        r_mem_addr  <= r_b1_addr;
        r_mem_wstrb <= r_b1_strb;
        r_mem_wdata <= r_b1_data;
      end
`endif

      if (w_timeout) r_err <= 1'b1;

      if (w_last_ack && !r_we) r_rdata <= w_load_val;

      if (w_accept || w_beat_restart)      r_wait_cnt <= '0;
      else if (w_mem_req && !bus.mem_ack)  r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - scoreboard bench for lsu_mem_master
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if bus();

  lsu_mem_master #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reqc;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  int total = 0;
  int bad   = 0;
  int ack_wait = 0;
  bit never_ack = 1'b0;
  int wcnt = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic w, input logic [31:0] rd);
    beat_t b;
    b.addr = a; b.strb = s; b.wdata = d; b.we = w; b.rdata = rd;
    beat_q.push_back(b);
  endtask

  // Memory responder: acks each beat after ack_wait idle cycles, checks the beat.
  always @(negedge clk) begin : mem_model
    beat_t b;
    if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end
    if (!bus.mem_req) begin
      wcnt = 0;
    end else if (!never_ack) begin
      if (wcnt >= ack_wait) begin
        if (beat_q.size() == 0) begin
          check("unexp_mem_req", 32'(bus.mem_req), 32'd0);
        end else begin
          b = beat_q.pop_front();
          check("beat_addr",  bus.mem_addr, b.addr);
          check("beat_strb",  32'(bus.mem_wstrb), 32'(b.strb));
          check("beat_wdata", bus.mem_wdata, b.wdata);
          check("beat_we",    32'(bus.mem_we), 32'(b.we));
          bus.mem_rdata = b.rdata;
          bus.mem_ack   = 1'b1;
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_we       = we;
    bus.cpu_size     = size;
    bus.cpu_unsigned = uns;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = wdata;
    bus.cpu_valid    = 1'b1;
  endtask

  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] load_val,
                       input int exp_lat, input int exp_reqc, input string tag);
    rsp_t r;
    int   lat;
    int   reqc;
    bit   done;
    r.err   = exp_err;
    r.rdata = (!we && !exp_err) ? load_val : model_rdata;
    r.lat   = exp_lat;
    r.reqc  = exp_reqc;
    rsp_q.push_back(r);
    model_rdata = r.rdata;
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.cpu_ready), 32'd1);
    drive_req(we, size, uns, addr, wdata);
    @(posedge clk);
    lat = 0; reqc = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (lat == 0) bus.cpu_valid = 1'b0;
      lat++;
      if (bus.mem_req) reqc++;
      if (bus.cpu_done) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    r = rsp_q.pop_front();
    if (done) begin
      check({tag, "_err"},   32'(bus.cpu_err), 32'(r.err));
      check({tag, "_rdata"}, bus.cpu_rdata, r.rdata);
      check({tag, "_lat"},   32'(lat), 32'(r.lat));
      check({tag, "_reqc"},  32'(reqc), 32'(r.reqc));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int dcnt;
    bus.cpu_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'd0;
    bus.cpu_unsigned = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.cpu_ready), 32'd1);
    check("rst_done",  32'(bus.cpu_done),  32'd0);
    check("rst_err",   32'(bus.cpu_err),   32'd0);
    check("rst_req",   32'(bus.mem_req),   32'd0);
    check("rst_we",    32'(bus.mem_we),    32'd0);
    check("rst_rdata", bus.cpu_rdata,      32'h0);
    check("rst_addr",  bus.mem_addr,       32'h0);
    check("rst_strb",  32'(bus.mem_wstrb), 32'h0);
    check("rst_wdata", bus.mem_wdata,      32'h0);
    rst_n = 1'b1;

    // LW, two wait cycles
    ack_wait = 2;
    push_beat(32'h100, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 4, 3, "lw");

    // LB / LBU at lane 3
    ack_wait = 0;
    push_beat(32'h200, 4'h8, 32'h0, 1'b0, 32'h80112233);
    do_op(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 1'b0, 32'hFFFFFF80, 2, 1, "lb");
    push_beat(32'h200, 4'h8, 32'h0, 1'b0, 32'h80112233);
    do_op(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 1'b0, 32'h00000080, 2, 1, "lbu");

    // SH at offset 1, one wait cycle; rdata must stay 0x80
    ack_wait = 1;
    push_beat(32'h100, 4'h6, 32'h00ABCD00, 1'b1, 32'h0);
    do_op(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000ABCD, 1'b0, 32'h0, 3, 2, "sh");

    // LH signed at offset 2
    ack_wait = 0;
    push_beat(32'h100, 4'hC, 32'h0, 1'b0, 32'hFEDC1234);
    do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b0, 32'hFFFFFEDC, 2, 1, "lh");

    // Reserved size
    do_op(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1, 0, "rsvd");

    // Crossing SW with address wrap
`ifdef LSU_MISALIGN_SPLIT_EN
    push_beat(32'hFFFFFFFC, 4'hC, 32'h33440000, 1'b1, 32'h0);
    push_beat(32'h00000000, 4'h3, 32'h00001122, 1'b1, 32'h0);
    do_op(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344, 1'b0, 32'h0, 3, 2, "swx");
`else
    do_op(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344, 1'b1, 32'h0, 1, 0, "swx");
`endif

    // Crossing LW at offset 1, one wait cycle per beat
    ack_wait = 1;
`ifdef LSU_MISALIGN_SPLIT_EN
    push_beat(32'h1FC, 4'hE, 32'h0, 1'b0, 32'hAABBCCDD);
    push_beat(32'h200, 4'h1, 32'h0, 1'b0, 32'h11223344);
    do_op(1'b0, 2'd2, 1'b0, 32'h1FD, 32'h0, 1'b0, 32'h44AABBCC, 5, 4, "lwx");
`else
    do_op(1'b0, 2'd2, 1'b0, 32'h1FD, 32'h0, 1'b1, 32'h0, 1, 0, "lwx");
`endif

    // Stray ack while idle must be ignored
    @(negedge clk);
    #1 bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ready", 32'(bus.cpu_ready), 32'd1);
    check("stray_done",  32'(bus.cpu_done),  32'd0);
    check("stray_rdata", bus.cpu_rdata, model_rdata);

    // Timeout (TIMEOUT_CYCLES = 4)
    never_ack = 1'b1;
    do_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 1'b1, 32'h0, 5, 4, "tmo");
    @(negedge clk);
    check("tmo_ready_after", 32'(bus.cpu_ready), 32'd1);

    // Reset while BEAT0 waits
    @(negedge clk);
    drive_req(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    check("rstmid_req_before", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_req",   32'(bus.mem_req),   32'd0);
    check("rstmid_ready", 32'(bus.cpu_ready), 32'd1);
    check("rstmid_addr",  bus.mem_addr,       32'h0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.cpu_done) dcnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.cpu_done) dcnt++;
    end
    check("rstmid_no_done", 32'(dcnt), 32'd0);
    never_ack   = 1'b0;
    model_rdata = 32'h0;

    // Normal LW after reset
    ack_wait = 0;
    push_beat(32'h400, 4'hF, 32'h0, 1'b0, 32'h12345678);
    do_op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, 32'h12345678, 2, 1, "lw2");

    @(negedge clk);
    check("beats_left", 32'(beat_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
